// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector with runtime overlap mode,
// input qualifier and saturating match counter.
module seq_detector_param #(
  parameter int LEN = 5,
  parameter logic [LEN-1:0] PATTERN = 5'b11011,
  parameter int CNT_W = 8,
  localparam int SW = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             in_valid,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic [SW-1:0]    present,
  output logic [SW-1:0]    next
);

  localparam logic [SW-1:0]    FULL = SW'(LEN);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [LEN:0]     PW   = {1'b0, PATTERN};
  localparam logic [LEN:0]     ONES = '1;

  logic [LEN:0] w;

  // w = matched prefix with the new bit appended, right-aligned;
  // pick the longest pattern prefix that is a suffix of w.
  always_comb begin
    next = present;
    w    = '0;
    if (in_valid) begin
      if (present == FULL && !overlap) begin
        next = (x == PATTERN[LEN-1]) ? SW'(1) : '0;
      end else begin
        w    = ((PW >> (LEN - int'(present))) << 1)
             | {{LEN{1'b0}}, x};
        next = '0;
        for (int k = 1; k <= LEN; k++) begin
          if (k <= int'(present) + 1 &&
              (w & (ONES >> (LEN + 1 - k))) ==
              (PW >> (LEN - k)))
            next = SW'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      present     <= '0;
      match_count <= '0;
    end else begin
      present <= next;
      if (in_valid && next == FULL &&
          match_count != CMAX)
        match_count <= match_count + CNT_W'(1);
    end
  end

  assign out = (present == FULL);

endmodule
